// File: rtl/basic_spi_cu.sv
// SPI mode-0 (MSB first) master control unit: sequences datapath load/shift/sample strobes and drives SCLK/SS_n.
// Latency: wr edge to done pulse = 3 + 2*WIDTH*CLK_DIV cycles; busy spans 4 + 2*WIDTH*CLK_DIV cycles.
// Backpressure: wr and rd are ignored while busy; no request is queued.
module basic_spi_cu #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic wr,
    input  logic rd,
    output logic sclk,
    output logic ss_n,
    output logic we,
    output logic oe,
    output logic i_load,
    output logic i_en,
    output logic tbuf_mosi_oe,
    output logic miso_le,
    output logic done,
    output logic busy,
    output logic rx_valid
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        LOAD1,
        XFER,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [BW-1:0] bit_cnt;

    assign oe = rd & ~busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            phase        <= '0;
            bit_cnt      <= '0;
            sclk         <= 1'b0;
            ss_n         <= 1'b1;
            we           <= 1'b0;
            i_load       <= 1'b0;
            i_en         <= 1'b0;
            tbuf_mosi_oe <= 1'b0;
            miso_le      <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            rx_valid     <= 1'b0;
        end else begin
            i_en <= 1'b0;
            done <= 1'b0;
            if (oe) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    // The done cycle sits in IDLE with busy still high, so wr is ignored here.
                    if (done) begin
                        busy <= 1'b0;
                    end else if (wr) begin
                        state  <= LOAD0;
                        busy   <= 1'b1;
                        we     <= 1'b1;
                        i_load <= 1'b1;
                    end
                end
                LOAD0: begin
                    state <= LOAD1;
                    i_en  <= 1'b1;
                end
                LOAD1: begin
                    state        <= XFER;
                    we           <= 1'b0;
                    i_load       <= 1'b0;
                    ss_n         <= 1'b0;
                    tbuf_mosi_oe <= 1'b1;
                    sclk         <= 1'b0;
                    miso_le      <= 1'b0;
                    phase        <= '0;
                    bit_cnt      <= '0;
                end
                XFER: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        if (!sclk) begin
                            sclk    <= 1'b1;
                            miso_le <= 1'b1;
                        end else begin
                            // Falling edge: shift pulse for the next bit, or the final shift in DONE.
                            sclk    <= 1'b0;
                            miso_le <= 1'b0;
                            i_en    <= 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state        <= DONE;
                                ss_n         <= 1'b1;
                                tbuf_mosi_oe <= 1'b0;
                                bit_cnt      <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    rx_valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_basic_spi_cu.sv
// Bench for basic_spi_cu: two instances (CLK_DIV=2 and CLK_DIV=1), each with a behavioural SPI datapath,
// plus a clocked slave model; expected results are queued at write time and popped on done/oe.
module tb_basic_spi_cu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, wr = 1'b0, rd = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
    logic a_sclk, a_ss_n, a_we, a_oe, a_i_load, a_i_en, a_tbuf, a_miso_le, a_done, a_busy, a_rx_valid;
    logic b_sclk, b_ss_n, b_we, b_oe, b_i_load, b_i_en, b_tbuf, b_miso_le, b_done, b_busy, b_rx_valid;

    basic_spi_cu #(.WIDTH(16), .CLK_DIV(2)) u_a (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .sclk(a_sclk), .ss_n(a_ss_n), .we(a_we), .oe(a_oe),
        .i_load(a_i_load), .i_en(a_i_en), .tbuf_mosi_oe(a_tbuf), .miso_le(a_miso_le), .done(a_done),
        .busy(a_busy), .rx_valid(a_rx_valid)
    );
    basic_spi_cu #(.WIDTH(16), .CLK_DIV(1)) u_b (
        .clk(clk), .rst(rst), .wr(b_wr), .rd(b_rd), .sclk(b_sclk), .ss_n(b_ss_n), .we(b_we), .oe(b_oe),
        .i_load(b_i_load), .i_en(b_i_en), .tbuf_mosi_oe(b_tbuf), .miso_le(b_miso_le), .done(b_done),
        .busy(b_busy), .rx_valid(b_rx_valid)
    );

    int passed = 0, total = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Instance A datapath: shift register, MISO sample flop, rx buffer; plus slave and MOSI capture.
    logic [15:0] a_bus = '0, a_sh, a_rxb = '0, a_mo = '0, sl = '0, sl_word = '0;
    logic a_mq = 1'b0, loopback = 1'b1, p_ss = 1'b1, p_sclk = 1'b0;
    wire a_miso = loopback ? a_sh[15] : sl[15];

    always @(posedge a_i_en or negedge rst)
        if (!rst) a_sh <= '0;
        else if (a_i_load) a_sh <= a_we ? a_bus : 16'hDEAD;
        else a_sh <= {a_sh[14:0], a_mq};
    always @(posedge a_miso_le) begin
        a_mq <= a_miso;
        a_mo <= {a_mo[14:0], a_sh[15]};
    end
    always @(posedge clk) if (a_done) a_rxb <= a_sh;
    always @(posedge clk) begin
        p_ss   <= a_ss_n;
        p_sclk <= a_sclk;
        if (p_ss && !a_ss_n) sl <= sl_word;
        else if (p_sclk && !a_sclk && !a_ss_n) sl <= {sl[14:0], 1'b0};
    end

    // Instance A scoreboard.
    int exp_done_q[$];
    logic [15:0] exp_rx_q[$], exp_mosi_q[$];
    logic [15:0] cur_rx = '0;
    int rises = 0, ss_low = 0, line_bad = 0, done_cnt = 0;
    logic prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            rises = 0; ss_low = 0; line_bad = 0; prev_sclk = 1'b0;
        end else begin
            if (a_sclk && !prev_sclk) rises++;
            prev_sclk = a_sclk;
            if (!a_ss_n) ss_low++;
            if (a_miso_le !== a_sclk) line_bad++;
            if (a_sclk && a_ss_n) line_bad++;
            if (a_tbuf === a_ss_n) line_bad++;
            if (a_done) begin
                done_cnt++;
                check("done_expected", (exp_done_q.size() > 0), 1);
                if (exp_done_q.size() > 0) begin
                    check("done_cycle", cyc, exp_done_q.pop_front());
                    check("sclk_rises", rises, 16);
                    check("ss_low_cycles", ss_low, 64);
                    check("mosi_word", a_mo, exp_mosi_q.pop_front());
                    check("line_levels", line_bad, 0);
                    cur_rx = exp_rx_q.pop_front();
                end
                rises = 0; ss_low = 0; line_bad = 0;
            end
            if (a_oe) check("rd_data", a_rxb, cur_rx);
        end
    end

    // Instance B datapath (loopback) and monitor.
    logic [15:0] b_bus = '0, b_sh, b_rxb = '0;
    logic b_mq = 1'b0, b_prev = 1'b0;
    int b_rises = 0, b_last = 0, b_per_bad = 0, b_run = 0, b_ien_bad = 0, b_ien_cnt = 0, b_done_cyc = -1;
    int b_line_bad = 0;

    always @(posedge b_i_en or negedge rst)
        if (!rst) b_sh <= '0;
        else if (b_i_load) b_sh <= b_we ? b_bus : 16'hDEAD;
        else b_sh <= {b_sh[14:0], b_mq};
    always @(posedge b_miso_le) b_mq <= b_sh[15];
    always @(posedge clk) if (b_done) b_rxb <= b_sh;

    always @(negedge clk) begin
        if (b_sclk && !b_prev) begin
            if (b_rises > 0 && cyc - b_last != 2) b_per_bad++;
            b_last = cyc;
            b_rises++;
        end
        b_prev = b_sclk;
        if (b_i_en) b_run++;
        else if (b_run > 0) begin
            if (b_run != 1) b_ien_bad++;
            b_ien_cnt++;
            b_run = 0;
        end
        if (b_tbuf === b_ss_n || b_miso_le !== b_sclk) b_line_bad++;
        if (b_done) b_done_cyc = cyc;
    end

    // Bus data is held for the wr cycle plus two, then deliberately corrupted.
    task automatic write_a(input logic [15:0] w, input logic [15:0] rx_exp);
        a_bus = w;
        wr = 1'b1;
        exp_done_q.push_back(cyc + 68);
        exp_rx_q.push_back(rx_exp);
        exp_mosi_q.push_back(w);
        tick();
        wr = 1'b0;
        tick();
        tick();
        a_bus = 16'h0BAD;
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        while (a_busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check({name, "_finish"}, (n < 300), 1);
    endtask

    task automatic read_a();
        rd = 1'b1;
        #1;
        check("oe_on_rd", a_oe, 1);
        check("rx_valid_before_rd", a_rx_valid, 1);
        tick();
        rd = 1'b0;
        check("rx_valid_cleared", a_rx_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    initial begin
        int k, n;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ss_n", a_ss_n, 1);
        check("rst_sclk", a_sclk, 0);
        check("rst_busy", a_busy, 0);
        check("rst_rx_valid", a_rx_valid, 0);
        check("rst_oe", a_oe, 0);
        check("rst_we_ien", {a_we, a_i_load, a_i_en, a_tbuf, a_miso_le, a_done}, 0);
        rst = 1'b1;
        tick();

        loopback = 1'b1;
        write_a(16'hA55A, 16'hA55A);
        wait_idle_a("t1");
        read_a();

        loopback = 1'b0;
        sl_word = 16'h3C0F;
        write_a(16'hFFFF, 16'h3C0F);
        wait_idle_a("t2");
        read_a();

        loopback = 1'b1;
        write_a(16'h0F0F, 16'h0F0F);
        wait_idle_a("t3");
        check("t3_rx_valid", a_rx_valid, 1);

        write_a(16'hC3A5, 16'hC3A5);
        repeat (7) tick();
        wr = 1'b1;
        tick();
        wr = 1'b0;
        rd = 1'b1;
        #1;
        check("oe_while_busy", a_oe, 0);
        tick();
        rd = 1'b0;
        check("rx_valid_kept_busy", a_rx_valid, 1);
        check("busy_mid_xfer", a_busy, 1);
        wait_idle_a("t4");
        repeat (5) tick();
        check("no_extra_xfer_busy", a_busy, 0);
        check("done_count", done_cnt, 4);
        read_a();

        a_bus = 16'h1111;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        repeat (30) tick();
        check("abort_ss_low", a_ss_n, 0);
        #1;
        rst = 1'b0;
        #1;
        check("abort_ss_n_async", a_ss_n, 1);
        check("abort_busy", a_busy, 0);
        check("abort_sclk", a_sclk, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (80) tick();
        check("abort_no_done", done_cnt, 4);
        check("abort_idle_ss_n", a_ss_n, 1);

        b_bus = 16'h8001;
        b_wr = 1'b1;
        k = cyc;
        tick();
        b_wr = 1'b0;
        tick();
        tick();
        b_bus = 16'h0BAD;
        n = 0;
        while (b_busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check("b_finish", (n < 300), 1);
        check("b_done_cycle", b_done_cyc, k + 36);
        check("b_sclk_rises", b_rises, 16);
        check("b_sclk_period", b_per_bad, 0);
        check("b_ien_width", b_ien_bad, 0);
        check("b_ien_pulses", b_ien_cnt, 17);
        check("b_line_levels", b_line_bad, 0);
        check("b_rx_valid", b_rx_valid, 1);
        b_rd = 1'b1;
        #1;
        check("b_oe", b_oe, 1);
        check("b_rd_data", b_rxb, 16'h8001);
        tick();
        b_rd = 1'b0;
        check("b_rx_valid_cleared", b_rx_valid, 0);

        check("queue_drained", exp_done_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/basic_spi_cu.md
Name: basic_spi_cu

Overview:
Control unit for the basic SPI master datapath. It turns CPU read/write strobes into the datapath's strobes: tri-state enables, parallel load, the shift clock and the MISO sample clock. It also generates the bus-side SCLK and SS_n. It sits directly upstream of the datapath, between the CPU bus decode and the datapath control pins, and implements SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
WIDTH, 16, bits per transfer; must match the datapath width.
CLK_DIV, 2, clk cycles per SCLK half-period; minimum 1.

Ports:
clk  in  1  system clock; all state is updated on its rising edge.
rst  in  1  asynchronous, active-low reset.
wr  in  1  CPU write strobe. Starts a transfer when sampled high in IDLE.
rd  in  1  CPU read strobe for the received word.
sclk  out  1  SPI serial clock.
ss_n  out  1  SPI slave select, active-low.
we  out  1  datapath input tri-state enable (bus -> shift register).
oe  out  1  datapath output tri-state enable (rx buffer -> bus).
i_load  out  1  datapath shift register parallel-load select.
i_en  out  1  datapath shift register clock; the register acts on its rising edge.
tbuf_mosi_oe  out  1  MOSI driver enable.
miso_le  out  1  MISO sample flip-flop clock.
done  out  1  one-cycle pulse; the rx buffer captures the shift register on it.
busy  out  1  high while a transfer is in progress.
rx_valid  out  1  sticky flag: a received word is waiting to be read.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all counters 0.
  - Outputs: sclk=0, ss_n=1, we=0, i_load=0, i_en=0, tbuf_mosi_oe=0, miso_le=0, done=0, busy=0, rx_valid=0.
  - Reset mid-transfer aborts immediately, ss_n goes high, no done pulse is produced.
- All outputs are registered except oe.
  - oe = rd & ~busy (combinational).
  - rd while busy=1 is ignored.
- States: IDLE -> LOAD0 -> LOAD1 -> XFER -> DONE -> IDLE.
- IDLE:
  - wr=1 moves the FSM to LOAD0 on the next edge.
  - wr while busy=1 is ignored and no request is queued.
  - The CPU must hold data stable on the bus for the wr cycle plus 2 further cycles.
- LOAD0 (1 cycle): we=1, i_load=1, i_en=0, busy=1.
- LOAD1 (1 cycle): we=1, i_load=1, i_en=1. The rising edge of i_en loads the bus word into the shift register.
- XFER: WIDTH bits, each 2*CLK_DIV clk cycles.
  - Throughout: ss_n=0, tbuf_mosi_oe=1, we=0, i_load=0.
  - Each bit: low phase of CLK_DIV cycles with sclk=0, then high phase of CLK_DIV cycles with sclk=1.
  - miso_le mirrors sclk, so MISO is sampled on each SCLK rising edge.
  - i_en=1 for exactly the first clk cycle of each low phase after bit 0, and for the first cycle of DONE. This gives WIDTH shift pulses, each on the SCLK falling edge.
  - MOSI (shift register MSB) changes only on falling edges, so it is stable at every rising edge.
- Counters:
  - Phase counter: 0..CLK_DIV-1, wraps each half-period.
  - Bit counter: 0..WIDTH-1, increments at the end of each high phase. XFER exits after the high phase of bit WIDTH-1.
- DONE (1 cycle):
  - i_en=1 (final shift), sclk=0, ss_n=1, tbuf_mosi_oe=0.
  - done is asserted on the cycle after DONE, so the rx buffer captures after the final shift completes; busy stays 1 through that cycle.
- busy:
  - High from the cycle after wr is sampled until done deasserts.
  - Total busy time = 2 + 2*WIDTH*CLK_DIV + 2 cycles, i.e. 68 cycles at the defaults.
- rx_valid:
  - Set on the done cycle.
  - Cleared in a cycle where oe=1.
  - Set and clear cannot coincide, because busy=1 during done.
- Idle line levels: sclk=0 and ss_n=1 between transfers. No SCLK edges occur while ss_n=1.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release. Required: ss_n=1, sclk=0, busy=0, rx_valid=0, oe=0. Then hold rst=0 mid-XFER and check ss_n=1 asynchronously and that no done pulse occurs.
- Loopback (miso tied to mosi), CLK_DIV=2: write 16'hA55A. Required:
  - 16 SCLK rising edges.
  - ss_n low for 64 cycles.
  - done pulses once, 67 cycles after the wr edge.
  - rx_valid=1; rd returns 16'hA55A and clears rx_valid.
- Slave model returning 16'h3C0F while the CPU writes 16'hFFFF. Required:
  - MOSI is all ones over 16 bits.
  - Read returns 16'h3C0F.
  - MISO is sampled only on SCLK rising edges.
- A wr pulse 10 cycles into a transfer. Required: ignored, no extra LOAD state, bit count stays 16, a single done pulse.
- rd while busy=1. Required: oe stays 0 and rx_valid is unchanged. A rd one cycle after busy falls gives oe=1.
- CLK_DIV=1 with 16'h8001 in loopback. Required: each SCLK period is 2 cycles, i_en is high for exactly 1 cycle per bit, and the received word is 16'h8001.
